// File: rtl/enc_dec_pkg.sv
// Shared types and golden decode function for the 3-to-8 encoder/decoder family.
package enc_dec_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // Output-stage occupancy: OUT_FULL means the one-hot register holds an entry.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic onehot_t code2onehot(input code_t code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Code-in / one-hot-out handshake bundle; master drives codes and consumes one-hot.
interface onehot_decoder_seq_if;
  import enc_dec_pkg::*;

  logic    in_valid;
  logic    in_ready;
  code_t   in_code;
  logic    out_valid;
  logic    out_ready;
  onehot_t out_onehot;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out_valid,
    input  out_onehot,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out_valid,
    output out_onehot,
    input  out_ready
  );

endinterface

// File: rtl/sync_fifo_simple.sv
// Single-clock FIFO with combinational read port; pointers wrap at DEPTH (power of 2).
module sync_fifo_simple #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against misuse so count never leaves 0..DEPTH.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential 3-to-8 decoder: FIFO-buffered codes presented as a registered one-hot
// vector, with an enable that stalls and masks the output stage.
module onehot_decoder_seq
  import enc_dec_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  onehot_decoder_seq_if.slave  bus,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  code_t            fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_c;
  logic             load_c;

  out_state_e       state_q;
  onehot_t          onehot_q;
  logic             overflow_q;

  // Ready depends on stored state only, so a full FIFO refuses a push even on a pop cycle.
  assign bus.in_ready = !fifo_full;
  assign push_c       = bus.in_valid && !fifo_full;
  assign load_c       = en && !fifo_empty && ((state_q == OUT_EMPTY) || bus.out_ready);

  sync_fifo_simple #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (load_c),
    .wdata_i (bus.in_code),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output-stage FSM; the one-hot register is cleared whenever the stage empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OUT_EMPTY;
      onehot_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.in_valid && fifo_full) overflow_q <= 1'b1;
      case (state_q)
        OUT_EMPTY: begin
          if (load_c) begin
            onehot_q <= code2onehot(fifo_rdata);
            state_q  <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (load_c) begin
            onehot_q <= code2onehot(fifo_rdata);
            state_q  <= OUT_FULL;
          end else if (en && bus.out_ready) begin
            onehot_q <= '0;
            state_q  <= OUT_EMPTY;
          end
        end
        default: begin
          onehot_q <= '0;
          state_q  <= OUT_EMPTY;
        end
      endcase
    end
  end

  assign bus.out_valid  = en && (state_q == OUT_FULL);
  assign bus.out_onehot = en ? onehot_q : '0;
  assign level          = LVL_W'(fifo_count);
  assign overflow       = overflow_q;

endmodule
